// File: rtl/chn_burst_arbiter.sv
// Round-robin burst scheduler: drains per-channel FIFOs into the USB FIFO as
// framed bursts (sync word, {chn, len} word, payload), throttled by usb_afull.
module chn_burst_arbiter #(
  parameter int          NUM_CHN   = 2,
  parameter int          DW        = 16,
  parameter int          UW        = 11,
  parameter int          BURST_LEN = 512,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   flush,
  input  logic [NUM_CHN*UW-1:0]  chn_usedw,
  input  logic [NUM_CHN-1:0]     chn_empty,
  input  logic [NUM_CHN*DW-1:0]  chn_q,
  output logic [NUM_CHN-1:0]     chn_rdreq,
  input  logic                   usb_afull,
  output logic [15:0]            usb_din,
  output logic                   usb_wr,
  output logic                   busy,
  output logic [3:0]             cur_chn,
  output logic                   err_underflow
);

  // state | meaning
  // IDLE  | one cycle after reset/clr, then SCAN
  // SCAN  | test channel ptr for a qualifying fill level
  // HDR0  | write SYNC_WORD (waits on usb_afull)
  // HDR1  | write {sel, len} (waits on usb_afull)
  // READ  | issue len read strobes, throttled by usb_afull
  // DRAIN | last in-flight word reaches the USB port
  // NEXT  | advance ptr past the served channel
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_HDR0, S_HDR1, S_READ, S_DRAIN, S_NEXT
  } state_t;

  localparam logic [3:0]    LAST_CHN = 4'(NUM_CHN - 1);
  localparam logic [UW-1:0] BL_UW    = UW'(BURST_LEN);
  localparam logic [11:0]   BL_12    = 12'(BURST_LEN);

  state_t        state, state_nxt;
  logic [3:0]    ptr, ptr_nxt, sel;
  logic [11:0]   len, rd_left;
  logic          valid_d;
  logic          hdr0_wr, hdr1_wr, rd_en, take;

  logic [UW-1:0] usedw_a [16];
  logic [DW-1:0] q_a     [16];
  logic [15:0]   empty_a;
  logic [UW-1:0] usedw_cur;
  logic          qualify;
  logic [11:0]   len_cur;
  logic [15:0]   rd_vec;

  // Pad to 16 entries so a 4-bit channel index always fits the arrays.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      usedw_a[i] = '0;
      q_a[i]     = '0;
      empty_a[i] = 1'b1;
    end
    for (int i = 0; i < NUM_CHN; i++) begin
      usedw_a[i] = chn_usedw[i*UW +: UW];
      q_a[i]     = chn_q[i*DW +: DW];
      empty_a[i] = chn_empty[i];
    end
  end

  assign usedw_cur = usedw_a[ptr];
  assign qualify   = (usedw_cur >= BL_UW) || (flush && (usedw_cur != '0));
  assign len_cur   = (usedw_cur >= BL_UW) ? BL_12 : 12'(usedw_cur);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hdr0_wr   = 1'b0;
    hdr1_wr   = 1'b0;
    rd_en     = 1'b0;
    take      = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_SCAN;
      S_SCAN: begin
        if (qualify) begin
          take      = 1'b1;
          state_nxt = S_HDR0;
        end else begin
          ptr_nxt = (ptr == LAST_CHN) ? 4'd0 : ptr + 4'd1;
        end
      end
      S_HDR0: begin
        if (!usb_afull) begin
          hdr0_wr   = 1'b1;
          state_nxt = S_HDR1;
        end
      end
      S_HDR1: begin
        if (!usb_afull) begin
          hdr1_wr   = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (rd_left == 12'd0) begin
          state_nxt = S_DRAIN;
        end else if (!usb_afull) begin
          rd_en = 1'b1;
          if (rd_left == 12'd1) state_nxt = S_DRAIN;
        end
      end
      // The final strobe was in the last READ cycle, so its word is
      // registered onto usb_din at the end of this single DRAIN cycle.
      S_DRAIN: state_nxt = S_NEXT;
      S_NEXT: begin
        ptr_nxt   = (sel == LAST_CHN) ? 4'd0 : sel + 4'd1;
        state_nxt = S_SCAN;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clr) begin
      state_nxt = S_IDLE;
      ptr_nxt   = 4'd0;
      hdr0_wr   = 1'b0;
      hdr1_wr   = 1'b0;
      rd_en     = 1'b0;
      take      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr   <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel           <= 4'd0;
      len           <= 12'd0;
      rd_left       <= 12'd0;
      valid_d       <= 1'b0;
      usb_wr        <= 1'b0;
      usb_din       <= 16'h0;
      err_underflow <= 1'b0;
    end else if (clr) begin
      rd_left       <= 12'd0;
      valid_d       <= 1'b0;
      usb_wr        <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (take) begin
        sel     <= ptr;
        len     <= len_cur;
        rd_left <= len_cur;
      end else if (rd_en) begin
        rd_left <= rd_left - 12'd1;
      end
      valid_d <= rd_en;
      usb_wr  <= valid_d | hdr0_wr | hdr1_wr;
      if (valid_d)      usb_din <= q_a[sel];
      else if (hdr0_wr) usb_din <= SYNC_WORD;
      else if (hdr1_wr) usb_din <= {sel, len};
      if (rd_en && empty_a[sel]) err_underflow <= 1'b1;
    end
  end

  assign rd_vec    = rd_en ? (16'h1 << sel) : 16'h0;
  assign chn_rdreq = rd_vec[NUM_CHN-1:0];
  assign busy      = (state != S_IDLE) && (state != S_SCAN);
  assign cur_chn   = sel;

endmodule

// File: tb/tb_chn_burst_arbiter.sv
// Directed bench for chn_burst_arbiter: modelled channel FIFOs and USB FIFO,
// a table of single-burst vectors plus hand sequences for multi-cycle cases.
module tb_chn_burst_arbiter;
  localparam int NC = 2;
  localparam int UW = 11;
  localparam int BL = 512;

  logic              clk = 1'b0;
  logic              reset_n, clr, flush;
  logic [NC*UW-1:0]  chn_usedw;
  logic [NC-1:0]     chn_empty;
  logic [NC*16-1:0]  chn_q;
  logic [NC-1:0]     chn_rdreq;
  logic              usb_afull;
  logic [15:0]       usb_din;
  logic              usb_wr, busy, err_underflow;
  logic [3:0]        cur_chn;

  chn_burst_arbiter #(.NUM_CHN(NC), .DW(16), .UW(UW), .BURST_LEN(BL), .SYNC_WORD(16'hEB90)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .flush(flush),
    .chn_usedw(chn_usedw), .chn_empty(chn_empty), .chn_q(chn_q), .chn_rdreq(chn_rdreq),
    .usb_afull(usb_afull), .usb_din(usb_din), .usb_wr(usb_wr), .busy(busy),
    .cur_chn(cur_chn), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int          base  [NC];
  int          reads [NC];
  logic        force_empty;
  logic        model_en, model_afull;
  int          free, full_viol;
  logic [15:0] wq [$];
  int          n_pass, n_total;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      chn_usedw[c*UW +: UW] = UW'(base[c] - reads[c]);
      chn_empty[c]          = (base[c] == reads[c]) | force_empty;
    end
  end

  assign usb_afull = model_en ? model_afull : 1'b0;

  // Channel FIFO model: each read returns {chn, running read count}.
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (!reset_n) begin
        reads[c] <= 0;
      end else if (chn_rdreq[c]) begin
        reads[c]           <= reads[c] + 1;
        chn_q[c*16 +: 16]  <= {4'(c), 12'(reads[c])};
      end
    end
  end

  // USB FIFO model (depth 8, random consumer) and write capture.
  always @(negedge clk) begin
    if (usb_wr) begin
      wq.push_back(usb_din);
      if (model_en) begin
        if (free == 0) full_viol = full_viol + 1;
        else free = free - 1;
      end
    end
    if (model_en) begin
      if (free < 8 && $urandom_range(0, 2) == 0) free = free + 1;
      model_afull = (free <= 2) || ($urandom_range(0, 3) == 0);
    end else begin
      free        = 8;
      model_afull = 1'b0;
    end
  end

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic zero_fills();
    for (int c = 0; c < NC; c++) base[c] = reads[c];
    flush = 1'b0;
  endtask

  // Waits for busy to rise then fall; bc = number of busy cycles.
  task automatic wait_burst(string tag, output int bc);
    int t;
    t  = 0;
    bc = 0;
    while (!busy && t < 3000) begin @(negedge clk); t++; end
    if (!busy) begin
      n_total++;
      $display("FAIL %s start timeout: busy got 0 required 1", tag);
      bc = -1;
      return;
    end
    while (busy && bc < 6000) begin bc++; @(negedge clk); end
    if (busy) begin
      n_total++;
      $display("FAIL %s end timeout: busy got 1 required 0", tag);
    end
  endtask

  task automatic check_burst(string tag, int off, int chn, int len, int start);
    int bad;
    logic [15:0] exp_w;
    bad = 0;
    if (wq.size() < off + len + 2) begin
      chk({tag, " size"}, wq.size(), off + len + 2);
      return;
    end
    chk({tag, " sync"}, wq[off], 16'hEB90);
    chk({tag, " hdr1"}, wq[off+1], {4'(chn), 12'(len)});
    for (int k = 0; k < len; k++) begin
      exp_w = {4'(chn), 12'(start + k)};
      if (wq[off+2+k] !== exp_w) begin
        if (bad == 0) $display("FAIL %s payload[%0d]: got %h expected %h", tag, k, wq[off+2+k], exp_w);
        bad++;
      end
    end
    chk({tag, " payload_bad"}, bad, 0);
  endtask

  typedef struct {
    int f0;
    int f1;
    bit fl;
    int exp_chn;
    int exp_len;
  } vec_t;

  vec_t vt [6];

  initial begin
    int bc, s0, s1, st, viol0, rem, t;
    string tg;

    vt[0] = '{f0: 512, f1: 0,   fl: 1'b0, exp_chn: 0, exp_len: 512};
    vt[1] = '{f0: 0,   f1: 5,   fl: 1'b1, exp_chn: 1, exp_len: 5};
    vt[2] = '{f0: 700, f1: 0,   fl: 1'b0, exp_chn: 0, exp_len: 512};
    vt[3] = '{f0: 3,   f1: 600, fl: 1'b0, exp_chn: 1, exp_len: 512};
    vt[4] = '{f0: 3,   f1: 600, fl: 1'b1, exp_chn: 0, exp_len: 3};
    vt[5] = '{f0: 1,   f1: 0,   fl: 1'b1, exp_chn: 0, exp_len: 1};

    n_pass = 0; n_total = 0; full_viol = 0;
    reset_n = 1'b0; clr = 1'b0; flush = 1'b0; force_empty = 1'b0; model_en = 1'b0;
    for (int c = 0; c < NC; c++) base[c] = 0;

    repeat (3) @(negedge clk);
    chk("rst chn_rdreq", chn_rdreq, 0);
    chk("rst usb_wr", usb_wr, 0);
    chk("rst usb_din", usb_din, 0);
    chk("rst busy", busy, 0);
    chk("rst cur_chn", cur_chn, 0);
    chk("rst err_underflow", err_underflow, 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle writes", wq.size(), 0);

    // Table of single bursts
    for (int v = 0; v < 6; v++) begin
      tg = $sformatf("vec%0d", v);
      pulse_clr();
      wq.delete();
      base[0] = reads[0] + vt[v].f0;
      base[1] = reads[1] + vt[v].f1;
      flush   = vt[v].fl;
      st = reads[vt[v].exp_chn];
      wait_burst(tg, bc);
      zero_fills();
      check_burst(tg, 0, vt[v].exp_chn, vt[v].exp_len, st);
      chk({tg, " busy_cycles"}, bc, vt[v].exp_len + 4);
      chk({tg, " rdreq_count"}, reads[vt[v].exp_chn] - st, vt[v].exp_len);
      repeat (4) @(negedge clk);
      chk({tg, " busy_after"}, busy, 0);
      chk({tg, " no_extra_write"}, wq.size(), vt[v].exp_len + 2);
    end

    // Round-robin alternation with both channels full
    pulse_clr();
    wq.delete();
    s0 = reads[0]; s1 = reads[1];
    base[0] = reads[0] + 2000;
    base[1] = reads[1] + 2000;
    for (int i = 0; i < 4; i++) wait_burst($sformatf("rr%0d", i), bc);
    zero_fills();
    chk("rr total_writes", wq.size(), 4 * (BL + 2));
    for (int i = 0; i < 4; i++)
      check_burst($sformatf("rr%0d", i), i * (BL + 2), i % 2,  BL, ((i % 2) ? s1 : s0) + (i / 2) * BL);

    // Full burst under random usb_afull back-pressure
    pulse_clr();
    wq.delete();
    viol0 = full_viol;
    model_en = 1'b1;
    st = reads[0];
    base[0] = reads[0] + 512;
    wait_burst("afull", bc);
    zero_fills();
    repeat (2) @(negedge clk);
    model_en = 1'b0;
    chk("afull writes", wq.size(), BL + 2);
    check_burst("afull", 0, 0, BL, st);
    chk("afull full_violations", full_viol - viol0, 0);

    // clr 100 words into a burst, then a fresh framed burst
    pulse_clr();
    wq.delete();
    base[0] = reads[0] + 512;
    t = 0;
    while (wq.size() < 102 && t < 1000) begin @(negedge clk); t++; end
    chk("clr reached_100_words", (wq.size() >= 102) ? 1 : 0, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr usb_wr", usb_wr, 0);
    chk("clr busy", busy, 0);
    chk("clr chn_rdreq", chn_rdreq, 0);
    wq.delete();
    st  = reads[0];
    rem = base[0] - reads[0];
    flush = 1'b1;
    wait_burst("post_clr", bc);
    zero_fills();
    check_burst("post_clr", 0, 0, rem, st);

    // Underflow: sticky until clr
    pulse_clr();
    wq.delete();
    base[0] = reads[0] + 512;
    t = 0;
    while (wq.size() < 10 && t < 1000) begin @(negedge clk); t++; end
    chk("uf err_before", err_underflow, 0);
    force_empty = 1'b1;
    repeat (2) @(negedge clk);
    force_empty = 1'b0;
    chk("uf err_set", err_underflow, 1);
    wait_burst("uf", bc);
    zero_fills();
    chk("uf err_sticky", err_underflow, 1);
    chk("uf writes", wq.size(), BL + 2);
    pulse_clr();
    chk("uf err_cleared", err_underflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
